// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-wide data memory load/store sequencer.
// Request sizes, FSM state codes, byte counts, and load-extension helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // The reserved size encoding 2'b11 is handled exactly like a word.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size,
                                         input logic sign_en);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{sign_en & data[7]}}, data[7:0]};
      SZ_HALF: r = {{16{sign_en & data[15]}}, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Combinational zero/sign extender applied to the assembled load value.
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sign_en,
  output logic [31:0] ext
);

  assign ext = extend(data, size, sign_en);

endmodule

// File: rtl/dmem_lsu_sequencer.sv
// Big-endian byte sequencer between the pipeline load/store port and a 8-bit data memory.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word requests instead of executing them.
module dmem_lsu_sequencer
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  state_t            state_reg;
  logic [2:0]        k_reg;
  logic [2:0]        nb_reg;
  logic [1:0]        lat_reg;
  logic [1:0]        size_reg;
  logic              we_reg;
  logic              signed_reg;
  logic              trap_hold_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       asm_reg;
  logic [31:0]       rdata_hold_reg;
  logic [31:0]       wdata_aligned;
  logic [31:0]       ext_data;
  logic              last_byte;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_reg;
  logic req_mis;
  assign req_mis = misaligned(req_size, req_addr[1:0]);
`endif

  // Store data is left-justified once at accept so byte k is always wdata_reg[31:24].
  always_comb begin
    case (req_size)
      SZ_BYTE: wdata_aligned = {req_wdata[7:0], 24'h000000};
      SZ_HALF: wdata_aligned = {req_wdata[15:0], 16'h0000};
      default: wdata_aligned = req_wdata;
    endcase
  end

  assign last_byte = (k_reg == nb_reg - 3'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      k_reg          <= '0;
      nb_reg         <= '0;
      lat_reg        <= '0;
      size_reg       <= '0;
      we_reg         <= 1'b0;
      signed_reg     <= 1'b0;
      trap_hold_reg  <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      asm_reg        <= '0;
      rdata_hold_reg <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg     <= req_we;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            addr_reg   <= req_addr;
            wdata_reg  <= wdata_aligned;
            nb_reg     <= nbytes(req_size);
            k_reg      <= '0;
            lat_reg    <= '0;
            asm_reg    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_reg <= req_mis;
            if (req_mis) begin
              // Extra DONE cycle keeps the fault response two cycles after accept.
              state_reg     <= ST_DONE;
              trap_hold_reg <= 1'b1;
            end else begin
              state_reg <= ST_ISSUE;
            end
`else
            state_reg <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: begin
          addr_reg <= addr_reg + ADDR_W'(1);
          lat_reg  <= '0;
          if (we_reg) begin
            wdata_reg <= {wdata_reg[23:0], 8'h00};
            if (last_byte) begin
              state_reg <= ST_DONE;
            end else begin
              k_reg <= k_reg + 3'd1;
            end
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_reg == LAT_LAST) begin
            asm_reg <= {asm_reg[23:0], mem_rdata};
            if (last_byte) begin
              state_reg <= ST_DONE;
            end else begin
              k_reg     <= k_reg + 3'd1;
              state_reg <= ST_ISSUE;
            end
          end else begin
            lat_reg <= lat_reg + 2'd1;
          end
        end
        ST_DONE: begin
          if (trap_hold_reg) begin
            trap_hold_reg <= 1'b0;
          end else begin
            rdata_hold_reg <= ext_data;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  dmem_load_extend u_extend (
    .data    (asm_reg),
    .size    (size_reg),
    .sign_en (signed_reg),
    .ext     (ext_data)
  );

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_DONE) && !trap_hold_reg;
  // Stores and faults leave asm_reg cleared, so their response data is zero.
  assign resp_rdata = resp_valid ? ext_data : rdata_hold_reg;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign resp_misaligned = resp_valid & mis_reg;
`else
  assign resp_misaligned = 1'b0;
`endif

  assign mem_en    = (state_reg == ST_ISSUE);
  assign mem_rw    = !(mem_en && we_reg);
  assign mem_addr  = mem_en ? addr_reg : '0;
  assign mem_wdata = (mem_en && we_reg) ? wdata_reg[31:24] : 8'h00;

endmodule

// File: tb/tb_dmem_lsu_sequencer.sv
// Table-driven, scoreboarded bench for dmem_lsu_sequencer against a 512x8 memory model.
module tb_dmem_lsu_sequencer;

  localparam int ADDR_W  = 9;
  localparam int MEM_LAT = 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_nacc;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          start;
  } exp_t;

  typedef struct {
    logic [8:0] addr;
    logic       rw;
    logic [7:0] wd;
  } acc_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        rdata_q;

  logic [7:0] mem [512];
  logic       bd_we;
  logic [8:0] bd_addr;
  logic [7:0] bd_data;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   resp_count = 0;
  int   n_mem_en = 0;
  exp_t sb[$];
  acc_t acc_log[$];
  vec_t vecs[15];

  dmem_lsu_sequencer #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_en          (mem_en),
    .mem_rw          (mem_rw),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (rdata_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: one-cycle read latency, plus a backdoor write port for preloading.
  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en && !mem_rw) mem[mem_addr] <= mem_wdata;
    if (mem_en && mem_rw) rdata_q <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    acc_t a;
    forever begin
      @(negedge clock);
      if (mem_en === 1'b1) begin
        a.addr = mem_addr; a.rw = mem_rw; a.wd = mem_wdata;
        acc_log.push_back(a);
        n_mem_en++;
      end
      if (resp_valid === 1'b1) begin
        resp_count++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: resp_valid=1, required 0 (nothing outstanding)");
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_misaligned", 32'(resp_misaligned), 32'(e.mis));
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
          $display("resp: rdata=0x%08h mis=%0d latency=%0d", resp_rdata, resp_misaligned,
                   cyc - e.start);
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic bd_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clock);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic m, input int l);
    exp_t e;
    e.rdata = r; e.mis = m; e.lat = l; e.start = cyc;
    sb.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [8:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] tmp;
    acc_log.delete();
    @(negedge clock);
    req_valid = 1'b1;
    drive(v.we, v.size, v.sgn, v.addr, v.wdata);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    push_exp(v.exp_rdata, v.exp_mis, v.exp_lat);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    drive(~v.we, 2'($urandom), 1'($urandom), 9'($urandom), $urandom);
    wait_drain();
    $display("vec %0d: we=%0d size=%0d addr=0x%03h accesses=%0d", idx, v.we, v.size, v.addr,
             acc_log.size());
    chk("n_access", 32'(acc_log.size()), 32'(v.exp_nacc));
    for (int k = 0; k < acc_log.size() && k < v.exp_nacc; k++) begin
      chk("mem_addr_seq", 32'(acc_log[k].addr), 32'(9'(v.addr + 9'(k))));
      chk("mem_rw", 32'(acc_log[k].rw), 32'(!v.we));
      if (v.we) begin
        tmp = v.wdata >> (8 * (v.exp_nacc - 1 - k));
        chk("mem_wdata", 32'(acc_log[k].wd), 32'(tmp[7:0]));
      end
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [8:0] a, input logic [31:0] wd, input logic [31:0] er,
                              input logic em, input int el, input int na);
    vec_t v;
    v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_mis = em; v.exp_lat = el; v.exp_nacc = na;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int rc0;
    int ec0;

    vecs[0]  = mk(0, 2'b10, 0, 9'h000, 32'h0, 32'h84214365, 0, 9, 4);
    vecs[1]  = mk(0, 2'b00, 1, 9'h000, 32'h0, 32'hFFFFFF84, 0, 3, 1);
    vecs[2]  = mk(0, 2'b00, 0, 9'h000, 32'h0, 32'h00000084, 0, 3, 1);
    vecs[3]  = mk(0, 2'b01, 1, 9'h000, 32'h0, 32'hFFFF8421, 0, 5, 2);
    vecs[4]  = mk(0, 2'b01, 1, 9'h002, 32'h0, 32'h00004365, 0, 5, 2);
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[5]  = mk(0, 2'b01, 0, 9'h001, 32'h0, 32'h00000000, 1, 2, 0);
    vecs[6]  = mk(0, 2'b10, 0, 9'h002, 32'h0, 32'h00000000, 1, 2, 0);
    vecs[7]  = mk(1, 2'b01, 0, 9'h1FF, 32'h0000BEEF, 32'h0, 1, 2, 0);
    vecs[8]  = mk(0, 2'b01, 0, 9'h1FF, 32'h0, 32'h00000000, 1, 2, 0);
`else
    vecs[5]  = mk(0, 2'b01, 0, 9'h001, 32'h0, 32'h00002143, 0, 5, 2);
    vecs[6]  = mk(0, 2'b10, 0, 9'h002, 32'h0, 32'h43651234, 0, 9, 4);
    vecs[7]  = mk(1, 2'b01, 0, 9'h1FF, 32'h0000BEEF, 32'h0, 0, 3, 2);
    vecs[8]  = mk(0, 2'b01, 0, 9'h1FF, 32'h0, 32'h0000BEEF, 0, 5, 2);
`endif
    vecs[9]  = mk(1, 2'b00, 0, 9'h010, 32'h123456A5, 32'h0, 0, 2, 1);
    vecs[10] = mk(0, 2'b00, 1, 9'h010, 32'h0, 32'hFFFFFFA5, 0, 3, 1);
    vecs[11] = mk(1, 2'b10, 0, 9'h020, 32'hCAFEF00D, 32'h0, 0, 5, 4);
    vecs[12] = mk(0, 2'b10, 0, 9'h020, 32'h0, 32'hCAFEF00D, 0, 9, 4);
    vecs[13] = mk(0, 2'b11, 1, 9'h020, 32'h0, 32'hCAFEF00D, 0, 9, 4);
    vecs[14] = mk(0, 2'b01, 1, 9'h022, 32'h0, 32'hFFFFF00D, 0, 5, 2);

    reset = 1'b1; req_valid = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    drive(0, 2'b00, 0, 9'h000, 32'h0);

    for (int i = 0; i < 512; i++) bd_write(9'(i), 8'h00);
    bd_write(9'h000, 8'h84); bd_write(9'h001, 8'h21);
    bd_write(9'h002, 8'h43); bd_write(9'h003, 8'h65);
    bd_write(9'h004, 8'h12); bd_write(9'h005, 8'h34);
    bd_write(9'h040, 8'h11); bd_write(9'h041, 8'h22);
    bd_write(9'h042, 8'h33); bd_write(9'h043, 8'h44);

    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_mis", 32'(resp_misaligned), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;

    fork
      monitor();
    join_none

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mem_1ff_untouched", 32'(mem[9'h1FF]), 32'h00);
    chk("mem_000_untouched", 32'(mem[9'h000]), 32'h84);
`else
    chk("mem_1ff_wrap_store", 32'(mem[9'h1FF]), 32'hBE);
    chk("mem_000_wrap_store", 32'(mem[9'h000]), 32'hEF);
`endif
    chk("mem_010_byte_store", 32'(mem[9'h010]), 32'hA5);
    chk("mem_011_not_written", 32'(mem[9'h011]), 32'h00);

    // Back-to-back with req_valid held high; fields change right after the first accept.
    @(negedge clock);
    req_valid = 1'b1;
    drive(0, 2'b00, 1, 9'h020, 32'h0);
    chk("b2b_ready_first", 32'(req_ready), 32'd1);
    push_exp(32'hFFFFFFCA, 1'b0, 3);
    @(posedge clock);
    @(negedge clock);
    drive(0, 2'b00, 0, 9'h023, 32'h0);
    busy = 0;
    while (!req_ready && busy < 50) begin
      busy++;
      @(negedge clock);
    end
    chk("b2b_ready_low_cycles", 32'(busy), 32'd3);
    chk("b2b_first_resp_done", 32'(sb.size()), 32'd0);
    push_exp(32'h0000000D, 1'b0, 3);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    wait_drain();
    $display("b2b: ready low for %0d cycles between accepts", busy);

    // Reset during the third byte of a word store.
    @(negedge clock);
    req_valid = 1'b1;
    drive(1, 2'b10, 0, 9'h040, 32'hDEADBEEF);
    chk("rst_seq_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_seq_byte2_en", 32'(mem_en), 32'd1);
    chk("rst_seq_byte2_addr", 32'(mem_addr), 32'h042);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_mem_rw", 32'(mem_rw), 32'd1);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    rc0 = resp_count;
    ec0 = n_mem_en;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready_after_reset", 32'(req_ready), 32'd1);
    repeat (8) @(negedge clock);
    chk("abort_no_resp", 32'(resp_count), 32'(rc0));
    chk("abort_no_mem_en", 32'(n_mem_en), 32'(ec0));
    chk("abort_mem_043", 32'(mem[9'h043]), 32'h44);
    chk("abort_mem_040", 32'(mem[9'h040]), 32'hDE);
    chk("abort_mem_041", 32'(mem[9'h041]), 32'hAD);
    $display("reset abort: responses=%0d mem[0x43]=0x%02h", resp_count - rc0, mem[9'h043]);

    run_vec(vecs[12], 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
